// File: rtl/gpu_fb_writer.sv
// Rasterizer pixel stream to double-buffered framebuffer writer: filter, pixel FIFO,
// drain-then-swap sequencing and an optional back-buffer clear engine (FB_WR_CLEAR_EN).
module gpu_fb_writer #(
    parameter int H_RES      = 800,
    parameter int V_RES      = 600,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = $clog2(2 * H_RES * V_RES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] pixel_color,
    input  logic               pixel_valid,
    input  logic [10:0]        pixel_x,
    input  logic [10:0]        pixel_y,
    input  logic               frame_end,
    output logic               fb_wr_en,
    output logic [AW-1:0]      fb_wr_addr,
    output logic [COLOR_W-1:0] fb_wr_data,
    output logic               front_buf,
    output logic               swap_pulse,
    output logic               clear_busy,
    output logic               overflow
);
    localparam int NPIX  = H_RES * V_RES;
    localparam int OFF_W = $clog2(NPIX);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]  BUF1_BASE = AW'(NPIX);
    localparam logic [PTR_W:0] DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] ONE_C     = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {S_RUN, S_SWAP, S_CLEAR} state_t;

    state_t               state_q, state_d;
    logic [OFF_W-1:0]     fifo_off_q [FIFO_DEPTH];
    logic [COLOR_W-1:0]   fifo_col_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d, drain_q, drain_d;
    logic                 swap_pend_q, swap_pend_d;
    logic                 front_q, front_d;
    logic                 swap_pulse_q, swap_pulse_d;
    logic                 ovf_q, ovf_d;
    logic                 fb_en_q, fb_en_d;
    logic [AW-1:0]        fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0]   fb_data_q, fb_data_d;

    logic                 accept, full, go_swap, pop, push;
    logic [OFF_W-1:0]     pix_off;
    logic [AW-1:0]        back_base;

`ifdef FB_WR_CLEAR_EN
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(NPIX - 1);
    logic [OFF_W-1:0]     clr_addr_q, clr_addr_d;
    logic                 busy_q, busy_d;
`endif

    assign accept    = pixel_valid && (pixel_color != '0)
                       && (32'(pixel_x) < 32'(H_RES)) && (32'(pixel_y) < 32'(V_RES));
    assign pix_off   = OFF_W'(32'(pixel_y) * 32'(H_RES) + 32'(pixel_x));
    assign full      = (count_q == DEPTH_C);
    // The swap decision cycle never pops, so the next frame's pixels stay queued.
    assign go_swap   = (state_q == S_RUN) && swap_pend_q && (drain_q == '0);
    assign pop       = (state_q == S_RUN) && (count_q != '0) && !go_swap;
    assign push      = accept && (!full || pop);
    assign back_base = front_q ? '0 : BUF1_BASE;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_off_q[wr_ptr_q] <= pix_off;
            fifo_col_q[wr_ptr_q] <= pixel_color;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q;
        drain_d      = drain_q;
        swap_pend_d  = swap_pend_q;
        front_d      = front_q;
        swap_pulse_d = 1'b0;
        ovf_d        = ovf_q | (accept && full && !pop);
        fb_en_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
`ifdef FB_WR_CLEAR_EN
        clr_addr_d   = clr_addr_q;
        busy_d       = 1'b0;
`endif

        if (push && !pop) begin
            count_d = count_q + ONE_C;
        end else if (!push && pop) begin
            count_d = count_q - ONE_C;
        end

        // drain_cnt captures post-push occupancy so the same-cycle pixel joins the old frame.
        if (frame_end && !swap_pend_q) begin
            swap_pend_d = 1'b1;
            drain_d     = count_d;
        end else if (pop && (drain_q != '0)) begin
            drain_d = drain_q - ONE_C;
        end

        case (state_q)
            S_RUN: begin
                if (pop) begin
                    fb_en_d   = 1'b1;
                    fb_addr_d = back_base + AW'(fifo_off_q[rd_ptr_q]);
                    fb_data_d = fifo_col_q[rd_ptr_q];
                end
                if (go_swap) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                front_d      = ~front_q;
                swap_pulse_d = 1'b1;
                swap_pend_d  = 1'b0;
`ifdef FB_WR_CLEAR_EN
                clr_addr_d   = '0;
                state_d      = S_CLEAR;
`else
                state_d      = S_RUN;
`endif
            end
            S_CLEAR: begin
`ifdef FB_WR_CLEAR_EN
                fb_en_d    = 1'b1;
                fb_addr_d  = back_base + AW'(clr_addr_q);
                fb_data_d  = '0;
                busy_d     = 1'b1;
                clr_addr_d = clr_addr_q + OFF_W'(1);
                if (clr_addr_q == LAST_OFF) begin
                    state_d = S_RUN;
                end
`else
                state_d = S_RUN;
`endif
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drain_q      <= '0;
            swap_pend_q  <= 1'b0;
            front_q      <= 1'b0;
            swap_pulse_q <= 1'b0;
            ovf_q        <= 1'b0;
            fb_en_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
`ifdef FB_WR_CLEAR_EN
            clr_addr_q   <= '0;
            busy_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drain_q      <= drain_d;
            swap_pend_q  <= swap_pend_d;
            front_q      <= front_d;
            swap_pulse_q <= swap_pulse_d;
            ovf_q        <= ovf_d;
            fb_en_q      <= fb_en_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
`ifdef FB_WR_CLEAR_EN
            clr_addr_q   <= clr_addr_d;
            busy_q       <= busy_d;
`endif
        end
    end

    assign fb_wr_en   = fb_en_q;
    assign fb_wr_addr = fb_addr_q;
    assign fb_wr_data = fb_data_q;
    assign front_buf  = front_q;
    assign swap_pulse = swap_pulse_q;
    assign overflow   = ovf_q;
`ifdef FB_WR_CLEAR_EN
    assign clear_busy = busy_q;
`else
    assign clear_busy = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_fb_writer.sv
// Scoreboard bench for gpu_fb_writer at H_RES=8, V_RES=4, FIFO_DEPTH=4; expectations
// follow FB_WR_CLEAR_EN so the same bench covers both builds.
module tb_gpu_fb_writer;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int N  = H * V;
    localparam int D  = 4;
    localparam int CW = 8;
    localparam int AW = 6;
`ifdef FB_WR_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk         = 1'b0;
    logic          reset       = 1'b0;
    logic [CW-1:0] pixel_color = '0;
    logic          pixel_valid = 1'b0;
    logic [10:0]   pixel_x     = '0;
    logic [10:0]   pixel_y     = '0;
    logic          frame_end   = 1'b0;
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic [CW-1:0] fb_wr_data;
    logic          front_buf, swap_pulse, clear_busy, overflow;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [CW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  swap_cnt = 0;
    int  busy_cnt = 0;
    int  held_cnt = 0;
    bit  front_m  = 1'b0;
    bit  prev_front = 1'b0;
    bit  model_ovf  = 1'b0;

    gpu_fb_writer #(
        .H_RES(H), .V_RES(V), .COLOR_W(CW), .FIFO_DEPTH(D), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .pixel_color(pixel_color), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_end(frame_end),
        .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .front_buf(front_buf), .swap_pulse(swap_pulse),
        .clear_busy(clear_busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference model: accepted pixels land at back*N + y*H + x; while the clear runs
    // nothing drains, so at most D pixels survive until the clear ends.
    task automatic model_px(input bit v, input int x, input int y, input int c, input bit held);
        if (v && c != 0 && x < H && y < V) begin
            if (held && held_cnt >= D) begin
                model_ovf = 1'b1;
            end else begin
                exp_q.push_back('{a: AW'((front_m ? 0 : N) + y * H + x), d: CW'(c)});
                if (held) held_cnt++;
            end
        end
    endtask

    task automatic model_frame_end();
        if (CLR) begin
            for (int i = 0; i < N; i++) exp_q.push_back('{a: AW'((front_m ? N : 0) + i), d: '0});
        end
        front_m  = ~front_m;
        held_cnt = 0;
    endtask

    task automatic px(input bit v, input int x, input int y, input int c, input bit fe, input bit held);
        @(posedge clk);
        #1;
        pixel_valid = v;
        pixel_x     = 11'(x);
        pixel_y     = 11'(y);
        pixel_color = CW'(c);
        frame_end   = fe;
        model_px(v, x, y, c, held);
        if (fe) model_frame_end();
    endtask

    task automatic idle();
        px(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_swap(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = swap_pulse;
        end
        chk({name, "_seen"}, 32'(found), 32'(1));
        chk({name, "_front"}, 32'(front_buf), 32'(front_m));
        chk({name, "_nowrite"}, 32'(fb_wr_en), 32'(0));
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
        end
        chk(name, 32'(done), 32'(1));
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_wr_en"},   32'(fb_wr_en),   32'(0));
        chk({name, "_wr_addr"}, 32'(fb_wr_addr), 32'(0));
        chk({name, "_wr_data"}, 32'(fb_wr_data), 32'(0));
        chk({name, "_front"},   32'(front_buf),  32'(0));
        chk({name, "_swap"},    32'(swap_pulse), 32'(0));
        chk({name, "_busy"},    32'(clear_busy), 32'(0));
        chk({name, "_ovf"},     32'(overflow),   32'(0));
    endtask

    // Monitor: every write strobe consumes the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (reset) begin
            if (fb_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: actual addr %0d data %0h required no write",
                             fb_wr_addr, fb_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(fb_wr_addr), 32'(e.a));
                    chk("wr_data", 32'(fb_wr_data), 32'(e.d));
                end
            end
            if (swap_pulse || (front_buf != prev_front)) begin
                chk("swap_toggle", 32'(swap_pulse), 32'(front_buf != prev_front));
            end
            if (swap_pulse) swap_cnt++;
            if (clear_busy) busy_cnt++;
        end
        prev_front = front_buf;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, x, y, c, k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) idle();

        // Filter and one-cycle latency
        px(1'b1, 3, 2, 8'h5A, 1'b0, 1'b0);
        px(1'b1, 1, 1, 8'h00, 1'b0, 1'b0);
        px(1'b1, 9, 0, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_wr_en", 32'(fb_wr_en), 32'(1));
        chk("lat_addr", 32'(fb_wr_addr), 32'(51));
        idle();
        @(negedge clk);
        chk("single_write", 32'(fb_wr_en), 32'(0));
        wait_drain("drain_filter");
        chk("filter_front", 32'(front_buf), 32'(0));

        // Swap, clear, pixels during clear
        busy_cnt = 0;
        swap_cnt = 0;
        px(1'b1, 0, 0, 8'h21, 1'b0, 1'b0);
        px(1'b1, 7, 3, 8'h42, 1'b0, 1'b0);
        px(1'b1, 4, 1, 8'h63, 1'b1, 1'b0);
        idle();
        wait_swap("swap1");
        chk("busy_at_swap", 32'(clear_busy), 32'(0));
        @(negedge clk);
        chk("busy_after_swap", 32'(clear_busy), 32'(CLR));
        chk("swap_one_cycle", 32'(swap_pulse), 32'(0));
        repeat (3) idle();
        px(1'b1, 2, 3, 8'h81, 1'b0, CLR);
        px(1'b1, 5, 0, 8'h82, 1'b0, CLR);
        px(1'b1, 6, 2, 8'h83, 1'b0, CLR);
        idle();
        wait_drain("drain_clear1");
        chk("busy_cycles1", 32'(busy_cnt), CLR ? 32'(N) : 32'(0));
        chk("swap_count1", 32'(swap_cnt), 32'(1));
        chk("ovf_none", 32'(overflow), 32'(model_ovf));

        // Random frame into buffer 0, then overflow during the following clear
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 4) != 0) ? 1 : 0;
            x = int'($urandom_range(0, 10));
            y = int'($urandom_range(0, 5));
            c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            px(v[0], x, y, c, (i == 39), 1'b0);
        end
        idle();
        wait_swap("swap2");
        repeat (2) idle();
        for (int i = 0; i < 6; i++) px(1'b1, i, i % V, 8'hA0 + i, 1'b0, CLR);
        idle();
        wait_drain("drain_clear2");
        chk("ovf_flag", 32'(overflow), 32'(model_ovf));
        chk("busy_cycles2", 32'(busy_cnt), CLR ? 32'(N) : 32'(0));
        repeat (5) idle();
        chk("ovf_sticky", 32'(overflow), 32'(model_ovf));

        // Reset in the middle of a clear
        px(1'b1, 1, 2, 8'h11, 1'b0, 1'b0);
        px(1'b1, 2, 2, 8'h12, 1'b1, 1'b0);
        idle();
        wait_swap("swap3");
        k = 0;
        if (CLR) begin
            for (int i = 0; i < 100 && k < 10; i++) begin
                @(negedge clk);
                if (clear_busy) k++;
            end
        end else begin
            repeat (3) @(negedge clk);
            k = 10;
        end
        chk("clear_progress", 32'(k), 32'(10));
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        exp_q.delete();
        front_m   = 1'b0;
        held_cnt  = 0;
        model_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) idle();
        @(negedge clk);
        chk_reset_outputs("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_fb_writer.md
# gpu_fb_writer

Downstream of the GPU rasterizer pixel stream: accepts (color, x, y, valid, frame_end) pixels and turns them into write transactions on a double-buffered framebuffer memory port. Drops transparent (color 0) and out-of-screen pixels, and buffers accepted pixels in a small FIFO. On frame_end it drains the finished frame, swaps front/back buffers and, optionally, clears the new back buffer. The front buffer index goes to the scanout block.

## Interface
- H_RES, 800, horizontal resolution in pixels
- V_RES, 600, vertical resolution in pixels
- COLOR_W, 8, color width in bits
- FIFO_DEPTH, 16, pixel FIFO depth (power of two, ≥2)
- AW, $clog2(2*H_RES*V_RES), framebuffer address width (20 at defaults)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pixel_color  in  COLOR_W  pixel color from rasterizer
- pixel_valid  in  1  pixel qualifier
- pixel_x  in  11  pixel column
- pixel_y  in  11  pixel row
- frame_end  in  1  single-cycle pulse: last pixel of frame is at or before this cycle
- fb_wr_en  out  1  framebuffer write strobe
- fb_wr_addr  out  AW  write address = buf*H_RES*V_RES + y*H_RES + x
- fb_wr_data  out  COLOR_W  write data
- front_buf  out  1  buffer index currently owned by scanout; back buffer = ~front_buf
- swap_pulse  out  1  one-cycle pulse on the cycle front_buf toggles
- clear_busy  out  1  high while clear engine owns the write port
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full

## Operation
- Accept: pixel_valid && pixel_color != 0 && pixel_x < H_RES && pixel_y < V_RES. Everything else is discarded silently.
- Push: an accepted pixel is pushed with precomputed offset y*H_RES+x (sized for H_RES*V_RES-1) and color. If FIFO full and no pop that cycle: drop, set overflow. Full with simultaneous pop: push succeeds.
- drain_cnt: on frame_end, swap_pending←1 and drain_cnt←FIFO occupancy after this cycle's push/pop. The same-cycle pixel belongs to the ending frame. drain_cnt decrements on each pop while nonzero. A frame_end while swap_pending=1 is ignored.
- FSM states:
  - RUN: pop one entry per cycle if nonempty, write to ~front_buf base + offset. Go to SWAP when swap_pending && drain_cnt==0, with no pop that cycle.
  - SWAP: one cycle, no write. Toggle front_buf, pulse swap_pulse, clear swap_pending, clear_addr←0. Next state is CLEAR (macro defined) or RUN.
  - CLEAR: write 0 to new back base + clear_addr, one per cycle, clear_busy=1. No pops; pushes continue and may overflow. After clear_addr==H_RES*V_RES-1 is written, go to RUN. A frame_end during CLEAR sets swap_pending; the swap waits for RUN.
- Address arithmetic is unsigned. The base multiply uses the parameter constant; no runtime multiplier on the buffer index.

## Timing
- Reset (reset=0) forces: fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, front_buf=0, swap_pulse=0, clear_busy=0, overflow=0, FIFO empty, swap_pending=0, state RUN. Reset mid-clear aborts; memory contents are then undefined.
- Latency: a pixel accepted at edge N into an empty FIFO in RUN is written with fb_wr_en registered high after edge N+1 (one cycle), assuming a sustained rate of 1 pixel/cycle.
- fb_wr_en is high for exactly one cycle per write. Outputs are registered.
- Clear duration is exactly H_RES*V_RES cycles of clear_busy=1, starting the cycle after swap_pulse.

## Configuration
- FB_WR_CLEAR_EN defined: CLEAR state and clear engine present, as above.
- Not defined: SWAP goes directly to RUN. clear_busy is tied to 0, no zero writes are issued, and the back buffer retains the previous frame's contents.

## Test plan
Bench uses H_RES=8, V_RES=4, FIFO_DEPTH=4.
- Filter: pixels (x=3,y=2,c=0x5A), (x=1,y=1,c=0x00), (x=9,y=0,c=0x11), one per cycle after reset. Required: exactly one write, addr=32+19=51, data=0x5A, one cycle after acceptance; front_buf=0.
- Swap + clear (macro on): 3 pixels, then frame_end with the third pixel. Required: 3 writes to buffer 1, then swap_pulse and front_buf=1. Then 32 zero writes at addrs 0..31 with clear_busy high 32 cycles, then RUN.
- Pixels during clear: 3 pixels pushed mid-clear. Required: no pixel writes until clear ends, then the 3 written to buffer 0 in order; overflow stays 0.
- Overflow: 6 pixels mid-clear. Required: first 4 written after clear, last 2 lost, overflow=1 until reset.
- Macro off: same as swap scenario. Required: swap_pulse, then immediate RUN, zero clear writes, clear_busy=0 throughout.
- Reset mid-clear: reset low at clear cycle 10. Required: all outputs return to reset values asynchronously, front_buf=0, no further writes.
